// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
//   Shared definitions for the CPU data-port memory responder:
//   FSM state encodings, the maximum supported response latency and
//   the width of the latency counter.
package dmem_responder_pkg;

  // 2-bit FSM encodings for the responder handshake.
  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  // Largest legal LATENCY; the counter is sized to hold LATENCY-1.
  localparam int DMEM_LAT_MAX = 15;
  localparam int DMEM_CNT_W   = 4;

  // Counter load value for a given latency.
  function automatic logic [DMEM_CNT_W-1:0] dmem_cnt_load(input int lat);
    return DMEM_CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// dmem_bank
//   2^ADDR_WIDTH x 32-bit word array built from four byte-lane arrays so
//   each lane has its own write enable. Synchronous read with enable.
//   Array contents are never reset.
// Ports:
//   clk    in   clock
//   we     in   write request (qualified per lane by be)
//   be     in   [3:0] byte-lane enables, bit i covers wdata[8i+7:8i]
//   waddr  in   [ADDR_WIDTH-1:0] write word index
//   wdata  in   [31:0] lane-aligned write data
//   rd_en  in   read enable; rdata updates on the following edge only
//   raddr  in   [ADDR_WIDTH-1:0] read word index
//   rdata  out  [31:0] registered read word, held while rd_en is low
module dmem_bank #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // One independent byte array per lane keeps each lane a plain
  // single-write-port RAM.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (we && be[gi]) begin
        mem[waddr] <= wdata[8*gi +: 8];
      end
      if (rd_en) begin
        rd_q <= mem[raddr];
      end
    end

    assign rdata[8*gi +: 8] = rd_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the CPU data port. One outstanding request
//   at a time; byte-masked writes commit at the end of the response cycle,
//   reads return the full word LATENCY cycles after accept.
// Ports:
//   clk      in   clock
//   resetn   in   asynchronous active-low reset
//   req      in   request valid
//   wr       in   1 = write, 0 = read
//   wstrb    in   [3:0] byte-lane write enables (ignored on reads)
//   addr     in   [31:0] byte address, addr[ADDR_WIDTH+1:2] selects the word
//   wdata    in   [31:0] lane-aligned write data
//   addr_ok  out  high in IDLE; req && addr_ok accepts a request
//   data_ok  out  one-cycle response strobe
//   rdata    out  [31:0] read word (0 for write responses), held until the
//                 next response
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  dmem_state_e                 state_q, state_d;
  logic [DMEM_CNT_W-1:0]       cnt_q, cnt_d;
  logic                        wr_q, wr_d;
  logic [3:0]                  wstrb_q, wstrb_d;
  logic [ADDR_WIDTH-1:0]       idx_q, idx_d;
  logic [31:0]                 wdata_q, wdata_d;
  // Set when the response in flight (or last delivered) was a read;
  // selects the bank read register onto rdata, otherwise rdata is 0.
  logic                        rd_resp_q, rd_resp_d;

  logic [ADDR_WIDTH-1:0]       req_idx;
  logic                        rd_en;
  logic [ADDR_WIDTH-1:0]       raddr;
  logic                        bank_we;
  logic [31:0]                 bank_rdata;

  assign req_idx = addr[ADDR_WIDTH+1:2];

  // Byte offset and high address bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    wstrb_d   = wstrb_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    rd_resp_d = rd_resp_q;
    rd_en     = 1'b0;
    addr_ok   = 1'b0;
    data_ok   = 1'b0;

    case (state_q)
      DMEM_IDLE: begin
        addr_ok = 1'b1;
        if (req) begin
          wr_d    = wr;
          wstrb_d = wstrb;
          idx_d   = req_idx;
          wdata_d = wdata;
          cnt_d   = dmem_cnt_load(LATENCY);
          if (LATENCY == 1) begin
            // Entering RESP on the accept edge: read straight from the
            // request address since idx_q is not loaded yet.
            state_d   = DMEM_RESP;
            rd_en     = ~wr;
            rd_resp_d = ~wr;
          end else begin
            state_d = DMEM_WAIT;
          end
        end
      end
      DMEM_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == DMEM_CNT_W'(1)) begin
          state_d   = DMEM_RESP;
          rd_en     = ~wr_q;
          rd_resp_d = ~wr_q;
        end
      end
      DMEM_RESP: begin
        data_ok = 1'b1;
        state_d = DMEM_IDLE;
      end
      default: begin
        state_d = DMEM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= DMEM_IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      wstrb_q   <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      rd_resp_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      wstrb_q   <= wstrb_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      rd_resp_q <= rd_resp_d;
    end
  end

  // Commit happens on the edge that ends RESP, so a dropped transaction
  // (reset before that edge) never touches the array.
  assign bank_we = (state_q == DMEM_RESP) && wr_q;
  assign raddr   = (state_q == DMEM_IDLE) ? req_idx : idx_q;

  dmem_bank #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .be    (wstrb_q),
    .waddr (idx_q),
    .wdata (wdata_q),
    .rd_en (rd_en),
    .raddr (raddr),
    .rdata (bank_rdata)
  );

  // The bank read register only reloads on read entry to RESP, so rdata
  // holds its value until the next response.
  assign rdata = rd_resp_q ? bank_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Three responder instances with different parameters:
//     dut0: ADDR_WIDTH=10, LATENCY=2  (basic write/read, byte lanes, zero strobe)
//     dut1: ADDR_WIDTH=4,  LATENCY=1  (aliasing, back-to-back reads)
//     dut2: ADDR_WIDTH=4,  LATENCY=4  (reset in the middle of a write)
//   Stimulus pushes expected responses into per-instance queues; a monitor
//   per instance pops and compares whenever data_ok is seen.
module tb_dmem_responder;

  localparam int NDUT = 3;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    int          id;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn  [NDUT];
  logic        req     [NDUT];
  logic        wr      [NDUT];
  logic [3:0]  wstrb   [NDUT];
  logic [31:0] addr    [NDUT];
  logic [31:0] wdata   [NDUT];
  logic        addr_ok [NDUT];
  logic        data_ok [NDUT];
  logic [31:0] rdata   [NDUT];

  exp_t exp_q [NDUT][$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int txn_id   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    dmem_responder #(
      .ADDR_WIDTH((gi == 0) ? 10 : 4),
      .LATENCY   ((gi == 0) ? 2 : ((gi == 1) ? 1 : 4))
    ) u_dut (
      .clk     (clk),
      .resetn  (resetn[gi]),
      .req     (req[gi]),
      .wr      (wr[gi]),
      .wstrb   (wstrb[gi]),
      .addr    (addr[gi]),
      .wdata   (wdata[gi]),
      .addr_ok (addr_ok[gi]),
      .data_ok (data_ok[gi]),
      .rdata   (rdata[gi])
    );

    exp_t mon_e;

    always @(negedge clk) begin
      if (resetn[gi] === 1'b1 && data_ok[gi] === 1'b1) begin
        if (exp_q[gi].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dut%0d_unexpected_data_ok: got data_ok=1 rdata=%h at cyc %0d expected no response",
                   gi, rdata[gi], cyc);
        end else begin
          mon_e = exp_q[gi].pop_front();
          $display("dut%0d txn %0d: rdata=%h cyc=%0d", gi, mon_e.id, rdata[gi], cyc);
          chk($sformatf("dut%0d_txn%0d_rdata", gi, mon_e.id), rdata[gi], mon_e.data);
          chk($sformatf("dut%0d_txn%0d_latency_cyc", gi, mon_e.id), 32'(cyc), 32'(mon_e.cyc));
          chk($sformatf("dut%0d_txn%0d_addr_ok_low", gi, mon_e.id), 32'(addr_ok[gi]), 32'h0);
        end
      end
    end
  end

  // Issue one request; waits (bounded) for addr_ok, then scrambles the
  // request inputs so a design that samples them late would be caught.
  task automatic issue(input int d, input logic w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_data, input bit expect_rsp);
    int n;
    exp_t e;
    @(negedge clk);
    req[d] = 1'b1; wr[d] = w; wstrb[d] = s; addr[d] = a; wdata[d] = wd;
    n = 0;
    while (addr_ok[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL dut%0d_accept_timeout: got addr_ok=%b expected 1 within 50 cycles", d, addr_ok[d]);
      req[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req[d] = 1'b0; wr[d] = ~w; wstrb[d] = 4'hF; addr[d] = 32'hFFFF_FFFC; wdata[d] = ~wd;
    if (expect_rsp) begin
      e.data = exp_data;
      e.cyc  = cyc + lat_of(d) - 1;
      e.id   = txn_id;
      exp_q[d].push_back(e);
    end
    txn_id++;
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (exp_q[d].size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q[d].size() != 0) begin
      checks++;
      failures++;
      $display("FAIL dut%0d_response_timeout: got %0d responses pending expected 0", d, exp_q[d].size());
      exp_q[d].delete();
    end
  endtask

  logic [31:0] b2b_addr [4] = '{32'h0000_0004, 32'h0000_0008, 32'h0000_000C, 32'h0000_0010};
  logic [31:0] b2b_exp  [4] = '{32'hCAFE_F00D, 32'h0A0B_0C0D, 32'h1122_3344, 32'h5566_7788};

  initial begin
    int n;
    int acc_cnt;
    int dok;
    exp_t e;

    for (int d = 0; d < NDUT; d++) begin
      resetn[d] = 1'b0; req[d] = 1'b0; wr[d] = 1'b0; wstrb[d] = 4'h0;
      addr[d] = 32'h0; wdata[d] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("dut%0d_reset_addr_ok", d), 32'(addr_ok[d]), 32'h1);
      chk($sformatf("dut%0d_reset_data_ok", d), 32'(data_ok[d]), 32'h0);
      chk($sformatf("dut%0d_reset_rdata", d), rdata[d], 32'h0);
    end
    for (int d = 0; d < NDUT; d++) resetn[d] = 1'b1;

    // dut0: full write then read, byte lanes, zero strobe
    issue(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b1);
    issue(0, 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b1);
    issue(0, 1'b1, 4'hF, 32'h20, 32'h1122_3344, 32'h0, 1'b1);
    issue(0, 1'b1, 4'b0100, 32'h20, 32'h00AA_0000, 32'h0, 1'b1);
    issue(0, 1'b0, 4'h0, 32'h20, 32'h0, 32'h11AA_3344, 1'b1);
    issue(0, 1'b1, 4'b0011, 32'h20, 32'h0000_BBCC, 32'h0, 1'b1);
    issue(0, 1'b0, 4'h0, 32'h20, 32'h0, 32'h11AA_BBCC, 1'b1);
    issue(0, 1'b1, 4'hF, 32'h0C, 32'h5555_5555, 32'h0, 1'b1);
    issue(0, 1'b1, 4'h0, 32'h0C, 32'h1234_5678, 32'h0, 1'b1);
    issue(0, 1'b0, 4'h0, 32'h0C, 32'h0, 32'h5555_5555, 1'b1);
    drain(0);

    // dut1: aliasing (0x47 -> word 1 with 16 words) and preload for b2b
    issue(1, 1'b1, 4'hF, 32'h04, 32'hCAFE_F00D, 32'h0, 1'b1);
    issue(1, 1'b0, 4'h0, 32'h47, 32'h0, 32'hCAFE_F00D, 1'b1);
    issue(1, 1'b1, 4'hF, 32'h08, 32'h0A0B_0C0D, 32'h0, 1'b1);
    issue(1, 1'b1, 4'hF, 32'h0C, 32'h1122_3344, 32'h0, 1'b1);
    issue(1, 1'b1, 4'hF, 32'h10, 32'h5566_7788, 32'h0, 1'b1);
    drain(1);

    // dut1: req held high for 4 reads; addr_ok/data_ok must alternate
    n = 0;
    @(negedge clk);
    while (addr_ok[1] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    req[1] = 1'b1; wr[1] = 1'b0; wstrb[1] = 4'h0;
    acc_cnt = 0;
    dok = 0;
    for (int c = 0; c < 8; c++) begin
      if (addr_ok[1] === 1'b1 && acc_cnt < 4) begin
        addr[1] = b2b_addr[acc_cnt];
        e.data = b2b_exp[acc_cnt];
        e.cyc  = cyc + lat_of(1);
        e.id   = txn_id;
        exp_q[1].push_back(e);
        txn_id++;
        acc_cnt++;
      end
      chk($sformatf("b2b_c%0d_addr_ok", c), 32'(addr_ok[1]), (c % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("b2b_c%0d_data_ok", c), 32'(data_ok[1]), (c % 2 == 1) ? 32'h1 : 32'h0);
      if (data_ok[1] === 1'b1) dok++;
      @(posedge clk);
      #1;
      if (acc_cnt == 4) req[1] = 1'b0;
      @(negedge clk);
    end
    chk("b2b_response_count", 32'(dok), 32'd4);
    drain(1);

    // dut2: reset during WAIT drops a pending write
    issue(2, 1'b1, 4'hF, 32'h08, 32'h0000_0000, 32'h0, 1'b1);
    drain(2);
    issue(2, 1'b1, 4'hF, 32'h08, 32'hFFFF_FFFF, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    resetn[2] = 1'b0;
    @(negedge clk);
    chk("rst_mid_addr_ok_in_reset", 32'(addr_ok[2]), 32'h1);
    chk("rst_mid_data_ok_in_reset", 32'(data_ok[2]), 32'h0);
    resetn[2] = 1'b1;
    dok = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (data_ok[2] === 1'b1) dok++;
    end
    chk("rst_mid_no_data_ok", 32'(dok), 32'd0);
    chk("rst_mid_addr_ok_after", 32'(addr_ok[2]), 32'h1);
    chk("rst_mid_rdata_after", rdata[2], 32'h0);
    issue(2, 1'b0, 4'h0, 32'h08, 32'h0, 32'h0000_0000, 1'b1);
    drain(2);

    for (int d = 0; d < NDUT; d++) drain(d);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
